opb_reg_access_arbiter: RTL and testbench

- Round-robin OPB master front-end that shares one OPB register bus between NUM_REQ local requesters (config sequencers, snapshot readers).
- Targets opb_register_simulink2ppc/ppc2simulink slaves within the register window.
- Runs one single-beat transaction at a time through a transaction FSM with timeout, retry and address-window checking.
- Returns read data or an error flag per request.

---
 rtl/opb_arb_pkg.sv | 28 ++
 rtl/opb_reg_access_arbiter_rr_arbiter.sv | 28 ++
 rtl/opb_reg_access_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_opb_reg_access_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/opb_arb_pkg.sv
// Shared types and helpers for the OPB register-access arbiter.
package opb_arb_pkg;

  localparam int OPB_AW  = 32;
  localparam int OPB_DW  = 32;
  localparam int MAX_REQ = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_XFER,
    ST_RETRY_GAP,
    ST_DONE
  } arb_state_e;

  // Pull requester idx's 32-bit field out of a flattened request bus.
  function automatic logic [OPB_DW-1:0] req_word(input logic [OPB_DW*MAX_REQ-1:0] bus,
                                                 input int idx);
    return bus[idx*OPB_DW +: OPB_DW];
  endfunction

  // Pull requester idx's byte-enable nibble out of a flattened request bus.
  function automatic logic [3:0] req_be_slice(input logic [4*MAX_REQ-1:0] bus,
                                              input int idx);
    return bus[idx*4 +: 4];
  endfunction

endpackage

// File: rtl/opb_reg_access_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  logic [IDX_W-1:0] cand;

  // Scan NUM_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/opb_reg_access_arbiter.sv
// OPB master front-end: shares one register bus between NUM_REQ requesters.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for any req; latches the round-robin winner
// ST_CHECK     | address window / alignment check, no bus activity
// ST_XFER      | M_select high, waiting for xferAck/errAck/retry/timeout
// ST_RETRY_GAP | one-cycle select drop before reissuing after Sl_retry
// ST_DONE      | done pulse to owner with rsp_err/rsp_rdata, bus idle
module opb_reg_access_arbiter
  import opb_arb_pkg::*;
#(
  parameter int          NUM_REQ     = 4,
  parameter logic [31:0] C_BASEADDR  = 32'h0108_0000,
  parameter logic [31:0] C_HIGHADDR  = 32'h0108_FFFF,
  parameter int          TOUT_CYCLES = 16,
  parameter int          MAX_RETRY   = 3
) (
  input  logic                  OPB_Clk,
  input  logic                  OPB_Rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_rnw,
  input  logic [32*NUM_REQ-1:0] req_addr,
  input  logic [32*NUM_REQ-1:0] req_wdata,
  input  logic [4*NUM_REQ-1:0]  req_be,
  output logic [NUM_REQ-1:0]    done,
  output logic                  rsp_err,
  output logic [31:0]           rsp_rdata,
  output logic [0:31]           M_ABus,
  output logic [0:3]            M_BE,
  output logic [0:31]           M_DBus,
  output logic                  M_RNW,
  output logic                  M_select,
  output logic                  M_seqAddr,
  input  logic [0:31]           Sl_DBus,
  input  logic                  Sl_xferAck,
  input  logic                  Sl_errAck,
  input  logic                  Sl_retry,
  input  logic                  Sl_toutSup
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TW    = $clog2(TOUT_CYCLES + 1);
  localparam int RW    = $clog2(MAX_RETRY + 1);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, grant_q, gnt_idx;
  logic                    gnt_vld;
  logic                    rnw_q, err_q, err_d;
  logic [OPB_AW-1:0]       addr_q;
  logic [OPB_DW-1:0]       wdata_q, rdata_q;
  logic [3:0]              be_q;
  logic [RW-1:0]           retry_q;
  logic [TW-1:0]           tout_q;
  logic                    cap_rd, retry_inc, tout_load, tout_dec, addr_ok;
  logic [OPB_AW*MAX_REQ-1:0] addr_ext, wdata_ext;
  logic [4*MAX_REQ-1:0]      be_ext;

  assign addr_ext  = (OPB_AW*MAX_REQ)'(req_addr);
  assign wdata_ext = (OPB_DW*MAX_REQ)'(req_wdata);
  assign be_ext    = (4*MAX_REQ)'(req_be);
  assign addr_ok   = (addr_q >= C_BASEADDR) && (addr_q <= C_HIGHADDR) && (addr_q[1:0] == 2'b00);
  assign M_seqAddr = 1'b0;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Next-state decode, counter strobes and state-decoded bus/response outputs.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    cap_rd    = 1'b0;
    retry_inc = 1'b0;
    tout_load = 1'b0;
    tout_dec  = 1'b0;
    M_select  = 1'b0;
    M_ABus    = '0;
    M_BE      = '0;
    M_DBus    = '0;
    M_RNW     = 1'b0;
    done      = '0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    unique case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        if (gnt_vld) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (!addr_ok) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          state_d   = ST_XFER;
          tout_load = 1'b1;
        end
      end
      ST_XFER: begin
        M_select = 1'b1;
        M_ABus   = addr_q;
        M_BE     = be_q;
        M_RNW    = rnw_q;
        M_DBus   = rnw_q ? '0 : wdata_q;
        if (Sl_errAck) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (Sl_xferAck) begin
          state_d = ST_DONE;
          err_d   = 1'b0;
          cap_rd  = rnw_q;
        end else if (Sl_retry) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_inc = 1'b1;
            state_d   = ST_RETRY_GAP;
          end else begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end else if (!Sl_toutSup) begin
          // Suppressed cycles neither count nor expire.
          if (tout_q == '0) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            tout_dec = 1'b1;
          end
        end
      end
      ST_RETRY_GAP: begin
        state_d   = ST_XFER;
        tout_load = 1'b1;
      end
      ST_DONE: begin
        state_d        = ST_IDLE;
        done[grant_q]  = 1'b1;
        rsp_err        = err_q;
        rsp_rdata      = (rnw_q && !err_q) ? rdata_q : '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request latch, round-robin pointer, retry and timeout counters.
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      rnw_q    <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      retry_q  <= '0;
      tout_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (state_q == ST_IDLE && gnt_vld) begin
        grant_q  <= gnt_idx;
        rnw_q    <= req_rnw[gnt_idx];
        addr_q   <= req_word(addr_ext, int'(gnt_idx));
        wdata_q  <= req_word(wdata_ext, int'(gnt_idx));
        be_q     <= req_be_slice(be_ext, int'(gnt_idx));
        rdata_q  <= '0;
        rr_ptr_q <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
      end
      if (cap_rd) rdata_q <= Sl_DBus;
      if (retry_inc) retry_q <= retry_q + 1'b1;
      if (tout_load) tout_q <= TW'(TOUT_CYCLES - 1);
      else if (tout_dec) tout_q <= tout_q - 1'b1;
      if (state_q == ST_DONE) begin
        retry_q <= '0;
        tout_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_opb_reg_access_arbiter.sv
// Directed bench: vector table of single transactions plus hand-written
// round-robin, retry, timeout and mid-transfer reset sequences.
module tb_opb_reg_access_arbiter;

  localparam int NR = 4;

  logic            OPB_Clk = 1'b0;
  logic            OPB_Rst_n;
  logic [NR-1:0]   req, req_rnw;
  logic [32*NR-1:0] req_addr, req_wdata;
  logic [4*NR-1:0] req_be;
  logic [NR-1:0]   done;
  logic            rsp_err;
  logic [31:0]     rsp_rdata;
  logic [0:31]     M_ABus, M_DBus, Sl_DBus;
  logic [0:3]      M_BE;
  logic            M_RNW, M_select, M_seqAddr;
  logic            Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_RETRY = 3, M_NONE = 4, M_SUP10 = 5;

  typedef struct {
    int          idx;
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          mode;
    logic [31:0] sdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic        exp_bus;
  } vec_t;

  typedef struct {
    int          ok;
    int          lat;
    int          sel_cycles;
    int          runs;
    int          max_gap;
    logic [NR-1:0] done;
    logic        err;
    logic [31:0] rdata;
    logic        sel_at_done;
    logic [31:0] abus;
    logic [31:0] dbus;
    logic [3:0]  be;
    logic        rnw;
  } obs_t;

  vec_t vt [9];

  opb_reg_access_arbiter dut (
    .OPB_Clk    (OPB_Clk),
    .OPB_Rst_n  (OPB_Rst_n),
    .req        (req),
    .req_rnw    (req_rnw),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .done       (done),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .M_ABus     (M_ABus),
    .M_BE       (M_BE),
    .M_DBus     (M_DBus),
    .M_RNW      (M_RNW),
    .M_select   (M_select),
    .M_seqAddr  (M_seqAddr),
    .Sl_DBus    (Sl_DBus),
    .Sl_xferAck (Sl_xferAck),
    .Sl_errAck  (Sl_errAck),
    .Sl_retry   (Sl_retry),
    .Sl_toutSup (Sl_toutSup)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic rnw, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    req[idx]              = 1'b1;
    req_rnw[idx]          = rnw;
    req_addr[idx*32 +: 32]  = addr;
    req_wdata[idx*32 +: 32] = wdata;
    req_be[idx*4 +: 4]      = be;
  endtask

  // Acts as the slave, one negedge at a time, until a done pulse or the bound.
  task automatic serve(input int mode, input logic [31:0] data, output obs_t o);
    int  gap;
    logic prev_sel;
    o = '{default: 0};
    gap = 0;
    prev_sel = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge OPB_Clk);
      Sl_xferAck = 1'b0; Sl_errAck = 1'b0; Sl_retry = 1'b0; Sl_toutSup = 1'b0; Sl_DBus = '0;
      if (done != '0) begin
        o.ok = 1; o.lat = c; o.done = done; o.err = rsp_err;
        o.rdata = rsp_rdata; o.sel_at_done = M_select;
        return;
      end
      if (M_select) begin
        if (!prev_sel) begin
          o.runs++;
          if (gap > o.max_gap) o.max_gap = gap;
        end
        if (o.sel_cycles == 0) begin
          o.abus = M_ABus; o.dbus = M_DBus; o.be = M_BE; o.rnw = M_RNW;
        end
        o.sel_cycles++;
        case (mode)
          M_ACK:   begin Sl_xferAck = 1'b1; Sl_DBus = data; end
          M_ERR:   Sl_errAck = 1'b1;
          M_BOTH:  begin Sl_xferAck = 1'b1; Sl_errAck = 1'b1; Sl_DBus = data; end
          M_RETRY: Sl_retry = 1'b1;
          M_SUP10: Sl_toutSup = (o.sel_cycles <= 10);
          default: ;
        endcase
      end else if (prev_sel) begin
        gap = 1;
      end else if (gap > 0) begin
        gap++;
      end
      prev_sel = M_select;
    end
  endtask

  initial begin
    obs_t o;
    vec_t v;
    int exp_g;

    vt[0] = '{0, 1'b1, 32'h0108_B300, 32'h0,         4'hF, M_ACK,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b1};
    vt[1] = '{2, 1'b0, 32'h0108_0000, 32'h1234_5678, 4'hF, M_ACK,  32'h0,         1'b0, 32'h0,         1'b1};
    vt[2] = '{1, 1'b0, 32'h0109_0000, 32'hCAFE_F00D, 4'hF, M_ACK,  32'h0,         1'b1, 32'h0,         1'b0};
    vt[3] = '{3, 1'b1, 32'h0108_FFFC, 32'h0,         4'h3, M_ACK,  32'hA5A5_0F0F, 1'b0, 32'hA5A5_0F0F, 1'b1};
    vt[4] = '{0, 1'b1, 32'h0107_FFFC, 32'h0,         4'hF, M_ACK,  32'h1111_1111, 1'b1, 32'h0,         1'b0};
    vt[5] = '{1, 1'b1, 32'h0108_0002, 32'h0,         4'hF, M_ACK,  32'h2222_2222, 1'b1, 32'h0,         1'b0};
    vt[6] = '{2, 1'b1, 32'h0108_0010, 32'h0,         4'hF, M_BOTH, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b1};
    vt[7] = '{3, 1'b0, 32'h0108_0020, 32'h5555_AAAA, 4'hC, M_ERR,  32'h0,         1'b1, 32'h0,         1'b1};
    vt[8] = '{0, 1'b1, 32'h0108_0004, 32'h0,         4'hF, M_ERR,  32'h3333_3333, 1'b1, 32'h0,         1'b1};

    OPB_Rst_n = 1'b0;
    req = '0; req_rnw = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    Sl_DBus = '0; Sl_xferAck = 1'b0; Sl_errAck = 1'b0; Sl_retry = 1'b0; Sl_toutSup = 1'b0;
    repeat (3) @(negedge OPB_Clk);
    chk("rst_done",     32'(done),      32'h0);
    chk("rst_select",   32'(M_select),  32'h0);
    chk("rst_abus",     M_ABus,         32'h0);
    chk("rst_dbus",     M_DBus,         32'h0);
    chk("rst_be_rnw",   {27'h0, M_BE, M_RNW}, 32'h0);
    chk("rst_rsp",      {rsp_rdata[30:0], rsp_err}, 32'h0);
    chk("rst_seqaddr",  32'(M_seqAddr), 32'h0);
    OPB_Rst_n = 1'b1;

    // Round robin: all four requesters hold req high.
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 32'h0108_0100 + 32'(4*i), 32'h0, 4'hF);
    for (int t = 0; t < 5; t++) begin
      exp_g = t % NR;
      serve(M_ACK, 32'hB000_0000 + 32'(t), o);
      chk("rr_bound",   32'(o.ok), 32'h1);
      chk("rr_grant",   32'(o.done), 32'h1 << exp_g);
      chk("rr_sel_low", 32'(o.sel_at_done), 32'h0);
      chk("rr_rdata",   o.rdata, 32'hB000_0000 + 32'(t));
      chk("rr_abus",    o.abus, 32'h0108_0100 + 32'(4*exp_g));
    end
    req = '0;
    @(negedge OPB_Clk);

    // Table of single transactions.
    for (int i = 0; i < 9; i++) begin
      v = vt[i];
      set_req(v.idx, v.rnw, v.addr, v.wdata, v.be);
      serve(v.mode, v.sdata, o);
      req = '0;
      chk($sformatf("v%0d_bound", i), 32'(o.ok), 32'h1);
      chk($sformatf("v%0d_done", i),  32'(o.done), 32'h1 << v.idx);
      chk($sformatf("v%0d_err", i),   32'(o.err), 32'(v.exp_err));
      chk($sformatf("v%0d_rdata", i), o.rdata, v.exp_rdata);
      chk($sformatf("v%0d_lat", i),   32'(o.lat), v.exp_bus ? 32'd3 : 32'd2);
      chk($sformatf("v%0d_selcyc", i), 32'(o.sel_cycles), v.exp_bus ? 32'd1 : 32'd0);
      if (v.exp_bus) begin
        chk($sformatf("v%0d_abus", i), o.abus, v.addr);
        chk($sformatf("v%0d_be", i),   32'(o.be), 32'(v.be));
        chk($sformatf("v%0d_rnw", i),  32'(o.rnw), 32'(v.rnw));
        chk($sformatf("v%0d_dbus", i), o.dbus, v.rnw ? 32'h0 : v.wdata);
      end
      @(negedge OPB_Clk);
    end

    // Four retries: three one-cycle select gaps, then error.
    set_req(1, 1'b1, 32'h0108_0040, 32'h0, 4'hF);
    serve(M_RETRY, 32'h0, o);
    req = '0;
    chk("retry_bound", 32'(o.ok), 32'h1);
    chk("retry_runs",  32'(o.runs), 32'd4);
    chk("retry_gap",   32'(o.max_gap), 32'd1);
    chk("retry_err",   32'(o.err), 32'h1);
    chk("retry_done",  32'(o.done), 32'h2);
    @(negedge OPB_Clk);

    // Timeout with no suppression: 16 XFER cycles.
    set_req(2, 1'b1, 32'h0108_0044, 32'h0, 4'hF);
    serve(M_NONE, 32'h0, o);
    req = '0;
    chk("tout_bound", 32'(o.ok), 32'h1);
    chk("tout_cyc",   32'(o.sel_cycles), 32'd16);
    chk("tout_err",   32'(o.err), 32'h1);
    chk("tout_rdata", o.rdata, 32'h0);
    @(negedge OPB_Clk);

    // Timeout with toutSup high for the first 10 XFER cycles: 26 cycles.
    set_req(3, 1'b0, 32'h0108_0048, 32'h0F0F_0F0F, 4'hF);
    serve(M_SUP10, 32'h0, o);
    req = '0;
    chk("tsup_bound", 32'(o.ok), 32'h1);
    chk("tsup_cyc",   32'(o.sel_cycles), 32'd26);
    chk("tsup_err",   32'(o.err), 32'h1);
    @(negedge OPB_Clk);

    // Reset in XFER: transaction dropped, pointer back to requester 0.
    set_req(2, 1'b1, 32'h0108_0050, 32'h0, 4'hF);
    for (int c = 0; c < 10; c++) begin
      @(negedge OPB_Clk);
      if (M_select) break;
    end
    chk("mrst_pre_sel", 32'(M_select), 32'h1);
    OPB_Rst_n = 1'b0;
    @(negedge OPB_Clk);
    chk("mrst_sel",  32'(M_select), 32'h0);
    chk("mrst_done", 32'(done), 32'h0);
    OPB_Rst_n = 1'b1;
    req = '0;
    set_req(3, 1'b1, 32'h0108_0060, 32'h0, 4'hF);
    set_req(0, 1'b1, 32'h0108_0064, 32'h0, 4'hF);
    serve(M_ACK, 32'h7777_0000, o);
    req = '0;
    chk("mrst_bound", 32'(o.ok), 32'h1);
    chk("mrst_grant", 32'(o.done), 32'h1);
    chk("mrst_rdata", o.rdata, 32'h7777_0000);
    @(negedge OPB_Clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
